// File: rtl/memory_pkg.sv
// Memory-stage shared types.
// Holds the execute/memory stage records, the data-bus request/response
// records, the access-size and load-extension encodings, the stage FSM
// state type, and two small helpers for byte masks and alignment.
package memory_pkg;

    // Access size; the encoding is log2 of the byte count.
    typedef enum logic [1:0] {
        MSIZE1 = 2'b00,
        MSIZE2 = 2'b01,
        MSIZE4 = 2'b10,
        MSIZE8 = 2'b11
    } msize_t;

    // Load extension mode.
    typedef enum logic {
        MEXT_ZERO = 1'b0,
        MEXT_SIGN = 1'b1
    } memext_t;

    typedef struct packed {
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        msize_t  msize;
        memext_t memext;
    } control_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dst;
        control_t    ctl;
        logic [63:0] aluout;   // address for memory ops, result otherwise
        logic [63:0] memwd;    // store data, byte 0 in bits [7:0]
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
        logic [63:0] result;
        logic        misalign;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    // Byte-enable pattern for an access of the given size at byte lane 0.
    function automatic logic [7:0] size_mask(input msize_t size);
        logic [7:0] mask;
        case (size)
            MSIZE1:  mask = 8'h01;
            MSIZE2:  mask = 8'h03;
            MSIZE4:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Natural alignment: the low log2(size) address bits must be zero.
    function automatic logic is_aligned(input logic [2:0] addr, input msize_t size);
        logic ok;
        case (size)
            MSIZE1:  ok = 1'b1;
            MSIZE2:  ok = (addr[0] == 1'b0);
            MSIZE4:  ok = (addr[1:0] == 2'b00);
            default: ok = (addr == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/memory_if.sv
// Data-bus interface between the memory stage and the data memory.
// Signals:
//   dreq  - request record from the stage (valid, addr, size, strobe, data)
//   dresp - response record from memory (addr_ok, data_ok, data)
// Handshake: the master raises dreq.valid and holds every dreq field
// stable until the cycle in which the slave returns data_ok=1; the access
// completes on that rising edge. data_ok plays the role of ready, addr_ok
// is informational only, and data_ok seen without a request means nothing.
interface memory_if;
    import memory_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/memory_readdata.sv
// Load data alignment and extension.
// Ports:
//   raw  - 64-bit word returned by the data bus
//   addr - byte offset of the access inside that word
//   size - access size
//   ext  - zero or sign extension
//   word - loaded value, right-justified and extended to 64 bits
module memory_readdata
    import memory_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [2:0]  addr,
    input  msize_t      size,
    input  memext_t     ext,
    output logic [63:0] word
);

    logic [63:0] shifted;
    logic        fill;

    always_comb begin
        shifted = raw >> {addr, 3'b000};
        fill    = 1'b0;
        word    = '0;
        case (size)
            MSIZE1: begin
                fill = (ext == MEXT_SIGN) & shifted[7];
                word = {{56{fill}}, shifted[7:0]};
            end
            MSIZE2: begin
                fill = (ext == MEXT_SIGN) & shifted[15];
                word = {{48{fill}}, shifted[15:0]};
            end
            MSIZE4: begin
                fill = (ext == MEXT_SIGN) & shifted[31];
                word = {{32{fill}}, shifted[31:0]};
            end
            default: begin
                word = shifted;
            end
        endcase
    end

endmodule

// File: rtl/memory.sv
// Pipeline memory stage.
// Non-memory instructions and misaligned memory ops pass through in one
// cycle. An aligned load/store is captured into a buffer and issued on the
// data bus; the stage stalls upstream until data_ok and then emits one
// dataM beat.
// Ports:
//   clk       - pipeline clock
//   reset     - asynchronous active-low reset
//   dataE     - execute-stage record, held upstream while stallM=1
//   stallM    - high while a bus access is outstanding
//   dbus      - data-bus master port (dreq out, dresp in)
//   dataM     - registered stage result
//   state_dbg - current FSM state
module memory
    import memory_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output logic          stallM,
    memory_if.master      dbus,
    output memory_data_t  dataM,
    output state_t        state_dbg
);

    state_t        state;
    execute_data_t buf_q;
    logic          mem_op;
    logic          aligned;
    logic [2:0]    lane;
    logic [63:0]   load_word;
    logic          unused_bits;

    assign mem_op    = dataE.ctl.memread | dataE.ctl.memwrite;
    assign aligned   = is_aligned(dataE.aluout[2:0], dataE.ctl.msize);
    assign lane      = buf_q.aluout[2:0];
    assign stallM    = (state == BUS);
    assign state_dbg = state;

    // Request fields come only from the buffer and state registers, so they
    // stay stable for the whole access and vanish as soon as reset hits.
    always_comb begin
        dbus.dreq = '0;
        if (state == BUS) begin
            dbus.dreq.valid  = 1'b1;
            dbus.dreq.addr   = buf_q.aluout;
            dbus.dreq.size   = buf_q.ctl.msize;
            dbus.dreq.strobe = buf_q.ctl.memwrite ? (size_mask(buf_q.ctl.msize) << lane) : 8'h00;
            dbus.dreq.data   = buf_q.memwd << {lane, 3'b000};
        end
    end

    memory_readdata u_readdata (
        .raw  (dbus.dresp.data),
        .addr (lane),
        .size (buf_q.ctl.msize),
        .ext  (buf_q.ctl.memext),
        .word (load_word)
    );

    function automatic memory_data_t stage_out(input execute_data_t e,
                                               input logic [63:0]   result,
                                               input logic          misalign);
        memory_data_t m;
        m           = '0;
        m.valid     = 1'b1;
        m.pc        = e.pc;
        m.raw_instr = e.raw_instr;
        m.dst       = e.dst;
        m.ctl       = e.ctl;
        m.result    = result;
        m.misalign  = misalign;
        return m;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            buf_q <= '0;
            dataM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dataE.valid && mem_op && aligned) begin
                        buf_q <= dataE;
                        state <= BUS;
                        dataM <= '0;
                    end else if (dataE.valid) begin
                        // A memory op reaching here is misaligned: it skips the bus.
                        dataM <= stage_out(dataE, dataE.aluout, mem_op);
                    end else begin
                        dataM <= '0;
                    end
                end
                BUS: begin
                    if (dbus.dresp.data_ok) begin
                        dataM <= stage_out(buf_q,
                                           buf_q.ctl.memread ? load_word : buf_q.aluout,
                                           1'b0);
                        state <= IDLE;
                    end else begin
                        dataM <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    dataM <= '0;
                end
            endcase
        end
    end

    // Fields carried through the buffer but not consumed by this stage.
    assign unused_bits = ^{buf_q.valid, buf_q.ra1, buf_q.ra2, dbus.dresp.addr_ok};

endmodule
